// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM initiator and its lane helper.
package mem_pkg;

  localparam int unsigned MAU_LANES  = 4;
  localparam int unsigned MAU_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_B   = 2'd0,
    MEM_H   = 2'd1,
    MEM_W   = 2'd2,
    MEM_RSV = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    LOAD_DATA = 2'd2,
    RESP      = 2'd3
  } mau_state_t;

  // True when the access cannot be made: unaligned half/word or reserved size.
  function automatic logic f_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return addr_lo[0];
      MEM_W:   return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response channels plus the RAM port, bundled for the initiator.
interface mem_access_unit_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_misaligned;
  logic          mem_re;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;
  logic          mem_we;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic [3:0]    mem_w_sel;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_r_data,
    output req_ready, rsp_valid, rsp_data, rsp_misaligned,
    output mem_re, mem_r_addr, mem_we, mem_w_addr, mem_w_data, mem_w_sel
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_r_data,
    input  req_ready, rsp_valid, rsp_data, rsp_misaligned,
    input  mem_re, mem_r_addr, mem_we, mem_w_addr, mem_w_data, mem_w_sel
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_t                  i_size,
  input  logic                       i_unsigned,
  input  logic [1:0]                 i_addr_lo,
  input  logic [MAU_DATA_W-1:0]      i_wdata,
  input  logic [MAU_DATA_W-1:0]      i_rdata,
  output logic [MAU_LANES-1:0]       o_w_sel_c,
  output logic [MAU_DATA_W-1:0]      o_w_data_c,
  output logic [MAU_DATA_W-1:0]      o_r_data_c
);

  logic [MAU_DATA_W-1:0] w_shifted;
  logic                  w_sign;

  // Select lanes / replicate store data and right-align plus extend load data.
  always_comb begin
    w_shifted  = i_rdata >> {i_addr_lo, 3'b000};
    w_sign     = 1'b0;
    o_w_sel_c  = '0;
    o_w_data_c = '0;
    o_r_data_c = '0;
    case (i_size)
      MEM_B: begin
        w_sign     = ~i_unsigned & w_shifted[7];
        o_w_sel_c  = 4'b0001 << i_addr_lo;
        o_w_data_c = {4{i_wdata[7:0]}};
        o_r_data_c = {{24{w_sign}}, w_shifted[7:0]};
      end
      MEM_H: begin
        w_sign     = ~i_unsigned & w_shifted[15];
        o_w_sel_c  = 4'b0011 << i_addr_lo;
        o_w_data_c = {2{i_wdata[15:0]}};
        o_r_data_c = {{16{w_sign}}, w_shifted[15:0]};
      end
      MEM_W: begin
        o_w_sel_c  = 4'b1111;
        o_w_data_c = i_wdata;
        o_r_data_c = w_shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the one-cycle-latency on-chip RAM.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AddrBusWidth = 32,
  parameter int unsigned DataBusWidth = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned AW = AddrBusWidth;
  localparam int unsigned DW = MAU_DATA_W;

  if (DataBusWidth != MAU_DATA_W) begin : g_dw_check
    $error("mem_access_unit: only DataBusWidth = 32 is supported");
  end

  mau_state_t        r_state, w_state_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]     r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_mis, w_rsp_mis_nxt;
  logic              r_mem_re, w_mem_re_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [AW-1:0]     r_mem_r_addr, w_mem_r_addr_nxt;
  logic [AW-1:0]     r_mem_w_addr, w_mem_w_addr_nxt;
  logic [DW-1:0]     r_mem_w_data, w_mem_w_data_nxt;
  logic [3:0]        r_mem_w_sel, w_mem_w_sel_nxt;

  logic              r_store;
  mem_size_t         r_size;
  logic              r_unsigned;
  logic [1:0]        r_addr_lo;

  mem_size_t         w_in_size;
  logic              w_accept;
  logic              w_misaligned;
  logic [AW-1:0]     w_word_addr;
  mem_size_t         w_al_size;
  logic [1:0]        w_al_lo;
  logic [3:0]        w_al_sel;
  logic [DW-1:0]     w_al_wdata;
  logic [DW-1:0]     w_al_rdata;

  assign w_in_size    = mem_size_t'(bus.req_size);
  assign w_accept     = (r_state == IDLE) && bus.req_valid && r_req_ready;
  assign w_misaligned = f_misaligned(w_in_size, bus.req_addr[1:0]);
  assign w_word_addr  = {bus.req_addr[AW-1:2], 2'b00};

  // Store steering uses the incoming request; load extraction uses the captured one.
  assign w_al_size = (r_state == IDLE) ? w_in_size : r_size;
  assign w_al_lo   = (r_state == IDLE) ? bus.req_addr[1:0] : r_addr_lo;

  mem_lane_align u_align (
    .i_size     (w_al_size),
    .i_unsigned (r_unsigned),
    .i_addr_lo  (w_al_lo),
    .i_wdata    (bus.req_wdata),
    .i_rdata    (bus.mem_r_data),
    .o_w_sel_c  (w_al_sel),
    .o_w_data_c (w_al_wdata),
    .o_r_data_c (w_al_rdata)
  );

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = 1'b0;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_mis_nxt    = r_rsp_mis;
    w_mem_re_nxt     = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_r_addr_nxt = '0;
    w_mem_w_addr_nxt = '0;
    w_mem_w_data_nxt = '0;
    w_mem_w_sel_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_rsp_data_nxt = '0;
          if (w_misaligned) begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_mis_nxt   = 1'b1;
          end else begin
            w_state_nxt   = ISSUE;
            w_rsp_mis_nxt = 1'b0;
            if (bus.req_store) begin
              w_mem_we_nxt     = 1'b1;
              w_mem_w_addr_nxt = w_word_addr;
              w_mem_w_sel_nxt  = w_al_sel;
              w_mem_w_data_nxt = w_al_wdata;
            end else begin
              w_mem_re_nxt     = 1'b1;
              w_mem_r_addr_nxt = w_word_addr;
            end
          end
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (r_store) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        // RAM data is only present this cycle, so it must be captured here.
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = w_al_rdata;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = IDLE;
          w_req_ready_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_mis_nxt   = 1'b0;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_mis    <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_r_addr <= '0;
      r_mem_w_addr <= '0;
      r_mem_w_data <= '0;
      r_mem_w_sel  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_mis    <= w_rsp_mis_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_r_addr <= w_mem_r_addr_nxt;
      r_mem_w_addr <= w_mem_w_addr_nxt;
      r_mem_w_data <= w_mem_w_data_nxt;
      r_mem_w_sel  <= w_mem_w_sel_nxt;
    end
  end

  // Request fields needed after the accept cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_store    <= bus.req_store;
      r_size     <= w_in_size;
      r_unsigned <= bus.req_unsigned;
      r_addr_lo  <= bus.req_addr[1:0];
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_data       = r_rsp_data;
  assign bus.rsp_misaligned = r_rsp_mis;
  assign bus.mem_re         = r_mem_re;
  assign bus.mem_r_addr     = r_mem_r_addr;
  // A write in flight must never reach the RAM while reset is asserted.
  assign bus.mem_we         = r_mem_we & ~rst;
  assign bus.mem_w_addr     = r_mem_w_addr;
  assign bus.mem_w_data     = r_mem_w_data;
  assign bus.mem_w_sel      = r_mem_w_sel;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios then random traffic against a byte-level memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(32), .DW(32)) bus ();

  mem_access_unit #(.AddrBusWidth(32), .DataBusWidth(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM environment: 16 words, one-cycle read latency, zero when not read.
  logic [31:0] ram [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_w_sel[i]) ram[bus.mem_w_addr[5:2]][8*i +: 8] <= bus.mem_w_data[8*i +: 8];
    bus.mem_r_data <= bus.mem_re ? ram[bus.mem_r_addr[5:2]] : 32'h0;
  end

  // Reference memory as plain bytes.
  logic [7:0] gold [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned f_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic f_bad(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd3) return 1'b1;
    return (ad % f_bytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic un, input logic [31:0] ad);
    logic [31:0] v = 32'h0;
    int unsigned n = f_bytes(sz);
    for (int k = 0; k < int'(n); k++) v = v + (32'(gold[int'(ad) + k]) << (8 * k));
    if (n < 4 && !un && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic run_req(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] ad,
                         input logic [31:0] wd, input int hold, output logic [31:0] got_data);
    logic        bad;
    int          exp_lat;
    logic [31:0] exp_data;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    int          n_re = 0;
    int          n_we = 0;
    int          lat = 0;
    logic        got = 1'b0;
    logic [31:0] re_addr = 32'h0;
    logic [31:0] we_addr = 32'h0;
    logic [31:0] we_data = 32'h0;
    logic [3:0]  we_sel = 4'h0;

    bad       = f_bad(sz, ad);
    exp_lat   = bad ? 1 : (st ? 2 : 3);
    exp_data  = (bad || st) ? 32'h0 : f_load(sz, un, ad);
    exp_sel   = (sz == 2'd2) ? 4'hF : 4'(((sz == 2'd0) ? 32'd1 : 32'd3) << ad[1:0]);
    exp_wdata = (sz == 2'd0) ? 32'(wd[7:0]) * 32'h01010101 :
                (sz == 2'd1) ? 32'(wd[15:0]) * 32'h00010001 : wd;

    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = ad;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.mem_re) begin n_re++; re_addr = bus.mem_r_addr; end
      if (bus.mem_we) begin n_we++; we_addr = bus.mem_w_addr; we_sel = bus.mem_w_sel; we_data = bus.mem_w_data; end
      if (bus.rsp_valid) begin got = 1'b1; lat = c; break; end
      @(posedge clk); #1;
    end
    got_data = bus.rsp_data;
    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_misaligned", 32'(bus.rsp_misaligned), 32'(bad));
    check("rsp_data", bus.rsp_data, exp_data);
    check("mem_re_count", 32'(n_re), (!bad && !st) ? 32'd1 : 32'd0);
    check("mem_we_count", 32'(n_we), (!bad && st) ? 32'd1 : 32'd0);
    if (!bad && !st) check("mem_r_addr", re_addr, ad & 32'hFFFF_FFFC);
    if (!bad && st) begin
      check("mem_w_addr", we_addr, ad & 32'hFFFF_FFFC);
      check("mem_w_sel", 32'(we_sel), 32'(exp_sel));
      check("mem_w_data", we_data, exp_wdata);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_data", bus.rsp_data, exp_data);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
    if (st && !bad)
      for (int k = 0; k < int'(f_bytes(sz)); k++) gold[int'(ad) + k] = 8'(wd >> (8 * k));
  endtask

  initial begin
    logic [31:0] d;
    logic        st;
    logic [1:0]  sz;
    logic [31:0] ad;

    for (int i = 0; i < 64; i++) gold[i] = 8'h0;
    bus.req_valid    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;

    // Reset held three cycles: every output quiet.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ctrl", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_misaligned, bus.mem_re, bus.mem_we, bus.mem_w_sel}), 32'd0);
      check("rst_data", bus.rsp_data | bus.mem_r_addr | bus.mem_w_addr | bus.mem_w_data, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);
    check("rel_mem_en", 32'({bus.mem_re, bus.mem_we, bus.rsp_valid}), 32'd0);

    // Word store, then byte/half loads with sign and zero extension.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, d);
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0102, 0, d);
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, d);
    check("lb_0x13", d, 32'hFFFFFF80);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, d);
    check("lbu_0x13", d, 32'h00000080);
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, d);
    check("lh_0x12", d, 32'hFFFF80FF);

    // Upper-half store keeps the lower half intact.
    run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 0, d);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, d);
    check("lw_after_sh", d, 32'hABCD0102);

    // Misaligned word and reserved size.
    run_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0, d);
    run_req(1'b1, 2'd3, 1'b0, 32'h00, 32'h12345678, 0, d);

    // Consumer stalls for five cycles.
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, d);

    // Reset while a load waits for RAM data: no response may follow.
    bus.req_store = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort_ld_issue_re", 32'(bus.mem_re), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ld_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_ld_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_ld_quiet", 32'({bus.rsp_valid, bus.mem_re, bus.mem_we}), 32'd0);
    end
    check("abort_ld_ready", 32'(bus.req_ready), 32'd1);

    // Reset during a store's write cycle must suppress the write.
    bus.req_store = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h20; bus.req_wdata = 32'h11223344;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_st_we_gated", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    check("abort_st_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, d);
    check("abort_st_no_write", d, 32'h0);

    // Random traffic checked against the byte model.
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7 && sz != 2'd3) ad = ad & ~32'(f_bytes(sz) - 1);
      run_req(st, sz, 1'($urandom_range(0, 1)), ad, $urandom, int'($urandom_range(0, 2)), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
